vga_scanout: RTL and testbench



---
 rtl/vga_pkg.sv | 25 ++
 rtl/vga_timing.sv | 48 ++++
 rtl/vga_scanout.sv | 90 +++++++++
 tb/tb_vga_scanout.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: VGA timing constants, colour type, expansion helper and shared colours (SCANOUT_TEST_PATTERN_EN selects a generated pattern in vga_scanout)
package vga_pkg;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP = 16;
  localparam int VGA_H_SYNC = 96;
  localparam int VGA_H_BP = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP = 10;
  localparam int VGA_V_SYNC = 2;
  localparam int VGA_V_BP = 33;
  typedef logic [5:0] cor_t;
  localparam cor_t COR_FRUIT = 6'b110000;
  localparam cor_t COR_OBSTACLE = 6'b111111;
  localparam cor_t COR_SNAKE1 = 6'b001100;
  localparam cor_t COR_SNAKE2 = 6'b001111;
  function automatic int h_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction
  function automatic int v_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction
  function automatic logic [23:0] expand(input cor_t c);
    return {{4{c[5:4]}}, {4{c[3:2]}}, {4{c[1:0]}}};
  endfunction
endpackage

// File: rtl/vga_timing.sv
// vga_timing: pixel/line counters, active-low sync levels, visible flag, vga_active and frame_start
module vga_timing import vga_pkg::*; #(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP = VGA_H_FP,
  parameter int H_SYNC = VGA_H_SYNC,
  parameter int H_BP = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP = VGA_V_FP,
  parameter int V_SYNC = VGA_V_SYNC,
  parameter int V_BP = VGA_V_BP
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_en,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       hsync,
  output logic       vsync,
  output logic       visible,
  output logic       vga_active,
  output logic       frame_start
);
  localparam int HT = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int VT = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  logic h_last, v_last;
  logic [9:0] v_next;
  assign h_last = h_cnt == 10'(HT - 1);
  assign v_last = v_cnt == 10'(VT - 1);
  assign v_next = !h_last ? v_cnt : v_last ? '0 : v_cnt + 10'd1;
  assign visible = h_cnt < 10'(H_ACTIVE) && v_cnt < 10'(V_ACTIVE);
  assign hsync = !(h_cnt >= 10'(H_ACTIVE + H_FP) && h_cnt < 10'(H_ACTIVE + H_FP + H_SYNC));
  assign vsync = !(v_cnt >= 10'(V_ACTIVE + V_FP) && v_cnt < 10'(V_ACTIVE + V_FP + V_SYNC));
  // advance the raster on pixel ticks; vga_active follows the line being entered, frame_start marks the full-frame wrap
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
      vga_active <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_en && h_last && v_last;
      if (pix_en) begin
        h_cnt <= h_last ? '0 : h_cnt + 10'd1;
        v_cnt <= v_next;
        vga_active <= v_next < 10'(V_ACTIVE);
      end
    end
endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: frame-buffer read stage, latency-matching delay pipeline and registered DAC outputs (SCANOUT_TEST_PATTERN_EN replaces buffer data with a counter pattern)
module vga_scanout import vga_pkg::*; #(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP = VGA_H_FP,
  parameter int H_SYNC = VGA_H_SYNC,
  parameter int H_BP = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP = VGA_V_FP,
  parameter int V_SYNC = VGA_V_SYNC,
  parameter int V_BP = VGA_V_BP,
  parameter int SCALE_LOG2 = 0,
  parameter int RD_LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_en,
  output logic [9:0] buffer_x,
  output logic [9:0] buffer_y,
  output logic       buffer_read,
  input  logic [5:0] buffer_cor,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic       vga_active,
  output logic       frame_start
);
  localparam int L = RD_LATENCY;
  localparam int PW = 6 * RD_LATENCY;
  logic [9:0] h_cnt, v_cnt;
  logic hsync, vsync, visible, rd_go;
  logic [L-1:0] hs_q, vs_q, vis_q;
  cor_t src;
  logic [23:0] rgb;
  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .h_cnt(h_cnt), .v_cnt(v_cnt), .hsync(hsync), .vsync(vsync), .visible(visible),
    .vga_active(vga_active), .frame_start(frame_start)
  );
`ifdef SCANOUT_TEST_PATTERN_EN
  logic [PW-1:0] pat_q;
  assign src = pat_q[PW-1 -: 6];
  assign rd_go = 1'b0;
  // carry the pattern colour alongside the syncs so it lines up with the delayed raster position
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pat_q <= '0;
    else if (pix_en) pat_q <= PW'({pat_q, h_cnt[8:7], h_cnt[6:5], v_cnt[7:6]});
`else
  assign src = buffer_cor;
  assign rd_go = visible;
`endif
  assign rgb = vis_q[L-1] ? expand(src) : '0;
  // issue one read strobe per visible tick; the address holds through blanking
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      buffer_read <= 1'b0;
      buffer_x <= '0;
      buffer_y <= '0;
    end else begin
      buffer_read <= pix_en && rd_go;
      if (pix_en && visible) begin
        buffer_x <= h_cnt >> SCALE_LOG2;
        buffer_y <= v_cnt >> SCALE_LOG2;
      end
    end
  // delay syncs and visibility by the buffer read latency, then register the DAC outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hs_q <= '1;
      vs_q <= '1;
      vis_q <= '0;
      vga_hs <= 1'b1;
      vga_vs <= 1'b1;
      vga_blank_n <= 1'b0;
      {vga_r, vga_g, vga_b} <= '0;
    end else if (pix_en) begin
      hs_q <= L'({hs_q, hsync});
      vs_q <= L'({vs_q, vsync});
      vis_q <= L'({vis_q, visible});
      vga_hs <= hs_q[L-1];
      vga_vs <= vs_q[L-1];
      vga_blank_n <= vis_q[L-1];
      {vga_r, vga_g, vga_b} <= rgb;
    end
endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: two scanout instances (latency 1 unscaled, latency 2 scaled by 8) on a reduced raster, checked against a tick-count model
module tb_vga_scanout;
  localparam int HA = 16, HF = 2, HS = 4, HB = 3, HT = HA + HF + HS + HB;
  localparam int VA = 10, VF = 2, VS = 2, VB = 3, VT = VA + VF + VS + VB;
  localparam int NT = HT * VT;
  logic clk = 0, rst_n = 0, pix_en = 0, run_en = 0;
  logic [9:0] bx1, by1, bx2, by2;
  logic rd1, rd2, hs1, vs1, bn1, act1, fs1, hs2, vs2, bn2, act2, fs2;
  logic [5:0] cor1, cor2;
  logic [7:0] r1, g1, b1, r2, g2, b2;
  int checks = 0, errors = 0;
  int k;
  logic ticked;
  logic [9:0] ebx1, eby1, ebx2, eby2;
  always #5 clk = ~clk;
  vga_scanout #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB), .V_ACTIVE(VA), .V_FP(VF),
    .V_SYNC(VS), .V_BP(VB), .SCALE_LOG2(0), .RD_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .buffer_x(bx1), .buffer_y(by1), .buffer_read(rd1),
    .buffer_cor(cor1), .vga_r(r1), .vga_g(g1), .vga_b(b1), .vga_hs(hs1), .vga_vs(vs1),
    .vga_blank_n(bn1), .vga_active(act1), .frame_start(fs1));
  vga_scanout #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB), .V_ACTIVE(VA), .V_FP(VF),
    .V_SYNC(VS), .V_BP(VB), .SCALE_LOG2(3), .RD_LATENCY(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .buffer_x(bx2), .buffer_y(by2), .buffer_read(rd2),
    .buffer_cor(cor2), .vga_r(r2), .vga_g(g2), .vga_b(b2), .vga_hs(hs2), .vga_vs(vs2),
    .vga_blank_n(bn2), .vga_active(act2), .frame_start(fs2));
  function automatic logic [5:0] mem(input logic [9:0] x, input logic [9:0] y);
    return x == 10'd3 ? 6'b110000 : {x[2:0], y[2:0]};
  endfunction
  // frame buffers: zero-wait for latency 1, one extra tick register for latency 2
  assign cor1 = mem(bx1, by1);
  always @(posedge clk) if (pix_en) cor2 <= mem(bx2, by2);
  function automatic int ph(input int n); return (n % NT) % HT; endfunction
  function automatic int pv(input int n); return (n % NT) / HT; endfunction
  function automatic logic vis(input int n); return ph(n) < HA && pv(n) < VA; endfunction
  function automatic logic [26:0] exp_out(input int j, input int s);
    int h, v;
    logic [5:0] c;
    if (j < 0) return {3'b110, 24'h0};
    h = ph(j);
    v = pv(j);
    c = mem(10'(h >> s), 10'(v >> s));
    return {!(h >= HA + HF && h < HA + HF + HS), !(v >= VA + VF && v < VA + VF + VS), vis(j),
            vis(j) ? {8'h55 * c[5:4], 8'h55 * c[3:2], 8'h55 * c[1:0]} : 24'h0};
  endfunction
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  // model: k = pixel ticks since reset; expected read addresses latch on visible ticks
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      k <= 0;
      ticked <= 1'b0;
      {ebx1, eby1, ebx2, eby2} <= '0;
    end else begin
      ticked <= pix_en;
      if (pix_en) begin
        k <= k + 1;
        if (vis(k)) begin
          ebx1 <= 10'(ph(k));
          eby1 <= 10'(pv(k));
          ebx2 <= 10'(ph(k) >> 3);
          eby2 <= 10'(pv(k) >> 3);
        end
      end
    end
  // per-cycle compare plus literal pins of the model
  always @(negedge clk) if (rst_n) begin
    chk("out1", {hs1, vs1, bn1, r1, g1, b1}, exp_out(k - 2, 0));
    chk("out2", {hs2, vs2, bn2, r2, g2, b2}, exp_out(k - 3, 3));
    chk("ctl1", {rd1, bx1, by1, act1, fs1}, {ticked && vis(k - 1), ebx1, eby1, k > 0 && pv(k) < VA,
        ticked && (k - 1) % NT == NT - 1});
    chk("ctl2", {rd2, bx2, by2, act2, fs2}, {ticked && vis(k - 1), ebx2, eby2, k > 0 && pv(k) < VA,
        ticked && (k - 1) % NT == NT - 1});
    if (ticked && k >= 2 && (k - 2) % NT == 3) chk("lit_fruit", {bn1, r1, g1, b1}, {1'b1, 24'hFF0000});
    if (ticked && k >= 2 && (k - 2) % NT == 2 * HT + 5) chk("lit_aa", {r1, g1, b1}, 24'hAAAAAA);
    if (ticked && k >= 2 && (k - 2) % NT == HT + 6) chk("lit_ff0055", {r1, g1, b1}, 24'hFF0055);
    if (ticked && k >= 3 && (k - 3) % NT == HT + 8) chk("lit_lat2", {bn2, r2, g2, b2}, {1'b1, 24'h00AA00});
    if (ticked && (k - 1) % NT == 9 * HT + 15) chk("lit_scale", {bx2, by2}, {10'd1, 10'd1});
    if (ticked && k >= NT && k % NT == 0) chk("lit_act_rise", act1, 1'b1);
    if (ticked && k % NT == VA * HT) chk("lit_act_fall", act1, 1'b0);
  end
  // pixel enable: every second clk while running
  initial forever begin
    @(posedge clk);
    #1 pix_en = run_en ? ~pix_en : 1'b0;
  end
  task automatic chk_reset();
    chk("rst1", {r1, g1, b1, hs1, vs1, bn1, act1, fs1, rd1, bx1, by1}, {24'h0, 2'b11, 4'b0, 20'h0});
    chk("rst2", {r2, g2, b2, hs2, vs2, bn2, act2, fs2, rd2, bx2, by2}, {24'h0, 2'b11, 4'b0, 20'h0});
  endtask
  task automatic wait_fs(input int bound, output int ticks);
    ticks = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (ticked) ticks++;
      if (fs1) return;
    end
    chk("fs_timeout", 1'b0, 1'b1);
  endtask
  initial begin
    int t, clks, rd_n, hs_n, vs_n, frz;
    repeat (3) @(negedge clk);
    #1 chk_reset();
    @(negedge clk);
    rst_n = 1;
    run_en = 1;
    wait_fs(4 * NT, t);
    chk("first_fs_ticks", t, NT);
    clks = 0; rd_n = 0; hs_n = 0; vs_n = 0;
    for (int i = 0; i < 4 * NT; i++) begin
      @(negedge clk);
      clks++;
      if (rd1) rd_n++;
      if (ticked && !hs1) hs_n++;
      if (ticked && !vs1) vs_n++;
      if (fs1) break;
    end
    chk("fs_period_clk", clks, 2 * NT);
    chk("reads_per_frame", rd_n, HA * VA);
    chk("hs_low_ticks", hs_n, HS * VT);
    chk("vs_low_ticks", vs_n, VS * HT);
    for (int i = 0; i < 4 * NT && !(ph(k) == 8 && pv(k) == 3); i++) @(negedge clk);
    run_en = 0;
    frz = 0;
    repeat (100) begin
      @(negedge clk);
      if (rd1 || rd2) frz++;
    end
    chk("freeze_reads", frz, 0);
    run_en = 1;
    for (int i = 0; i < 4 * NT && pv(k) != 5; i++) @(negedge clk);
    #2 rst_n = 0;
    #1 chk_reset();
    repeat (3) @(negedge clk);
    rst_n = 1;
    wait_fs(4 * NT, t);
    chk("fs_after_reset", t, NT);
    repeat (20) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1);
  end
endmodule
